// File: rtl/tcam_lut_if.sv
// Bus bundle for tcam_lut: write, scrub control, read-back, lookup and statistics.
interface tcam_lut_if #(
    parameter int AW = 4,
    parameter int DW = 16,
    parameter int CW = 32
);
    logic          WE;
    logic [AW-1:0] WR_ADDR;
    logic [DW-1:0] DIN;
    logic [DW-1:0] DATA_MASK;
    logic          WR_VALID;
    logic          FLUSH;
    logic          BUSY;
    logic          RD_EN;
    logic [AW-1:0] RD_ADDR;
    logic [DW-1:0] RD_DIN_OUT;
    logic [DW-1:0] RD_MASK_OUT;
    logic          RD_VALID_OUT;
    logic          RD_ACK;
    logic          CMP_REQ;
    logic [DW-1:0] CMP_DIN;
    logic [DW-1:0] CMP_DATA_MASK;
    logic          CMP_ACK;
    logic          MATCH;
    logic          MULTIPLE_MATCH;
    logic [AW-1:0] MATCH_ADDR;
    logic          CNT_CLR;
    logic [CW-1:0] LOOKUP_CNT;
    logic [CW-1:0] HIT_CNT;

    modport master (
        output WE, WR_ADDR, DIN, DATA_MASK, WR_VALID, FLUSH,
        output RD_EN, RD_ADDR, CMP_REQ, CMP_DIN, CMP_DATA_MASK, CNT_CLR,
        input  BUSY, RD_DIN_OUT, RD_MASK_OUT, RD_VALID_OUT, RD_ACK,
        input  CMP_ACK, MATCH, MULTIPLE_MATCH, MATCH_ADDR, LOOKUP_CNT, HIT_CNT
    );

    modport slave (
        input  WE, WR_ADDR, DIN, DATA_MASK, WR_VALID, FLUSH,
        input  RD_EN, RD_ADDR, CMP_REQ, CMP_DIN, CMP_DATA_MASK, CNT_CLR,
        output BUSY, RD_DIN_OUT, RD_MASK_OUT, RD_VALID_OUT, RD_ACK,
        output CMP_ACK, MATCH, MULTIPLE_MATCH, MATCH_ADDR, LOOKUP_CNT, HIT_CNT
    );
endinterface

// File: rtl/tcam_lut.sv
// Ternary CAM lookup table: masked entries, 2-cycle pipelined lookup with
// priority resolution, read-back, self-scrubbing after reset/flush, and
// saturating lookup/hit counters.
module tcam_lut #(
    parameter int C_TCAM_ADDR_WIDTH  = 4,
    parameter int C_TCAM_DATA_WIDTH  = 16,
    parameter int C_MATCH_RESOLUTION = 0,
    parameter int C_CNT_WIDTH        = 32
) (
    input logic       CLK,
    input logic       RESET,
    tcam_lut_if.slave bus
);
    localparam int AW = C_TCAM_ADDR_WIDTH;
    localparam int DW = C_TCAM_DATA_WIDTH;
    localparam int CW = C_CNT_WIDTH;
    localparam int D  = 1 << AW;

    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [D-1:0]  HIT_ONE = {{(D-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE, ST_SCRUB} state_t;

    // Table storage: no reset so it maps onto RAM
    logic [DW-1:0] data_mem [D];
    logic [DW-1:0] mask_mem [D];

    state_t        state_q;
    logic [AW-1:0] scrub_ptr_q;
    logic          busy_q;

    logic [D-1:0]  valid_q, valid_d;
    logic          wr_en, wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data, wr_mask;

    logic [D-1:0]  hit_vec;
    logic          req1_q, req1_d;
    logic [D-1:0]  hit1_q, hit1_d;
    logic          ack_q, ack_d;
    logic          match_q, match_d;
    logic          multi_q, multi_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [AW-1:0] win_addr;
    logic          win_found;

    logic          rd_ack_q, rd_ack_d;
    logic [DW-1:0] rd_din_q, rd_din_d;
    logic [DW-1:0] rd_mask_q, rd_mask_d;
    logic          rd_valid_q, rd_valid_d;

    logic [CW-1:0] lookup_cnt_q, lookup_cnt_d;
    logic [CW-1:0] hit_cnt_q, hit_cnt_d;

    // Scrub FSM: sweeps every entry once after reset or an accepted flush
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_SCRUB;
            scrub_ptr_q <= '0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.FLUSH) begin
                        state_q     <= ST_SCRUB;
                        scrub_ptr_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_SCRUB: begin
                    if (scrub_ptr_q == '1) begin
                        state_q     <= ST_IDLE;
                        scrub_ptr_q <= '0;
                        busy_q      <= 1'b0;
                    end else begin
                        scrub_ptr_q <= scrub_ptr_q + PTR_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Single write port shared by the scrubber (priority) and external writes
    always_comb begin
        wr_en    = busy_q | bus.WE;
        wr_addr  = bus.WR_ADDR;
        wr_data  = bus.DIN;
        wr_mask  = bus.DATA_MASK;
        wr_valid = bus.WR_VALID;
        if (busy_q) begin
            wr_addr  = scrub_ptr_q;
            wr_data  = '0;
            wr_mask  = '0;
            wr_valid = 1'b0;
        end
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_addr] = wr_valid;
        end
    end

    // Data/mask RAM write
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            data_mem[wr_addr] <= wr_data;
            mask_mem[wr_addr] <= wr_mask;
        end
    end

    // Per-entry ternary compare against the pre-edge table contents
    always_comb begin
        hit_vec = '0;
        for (int unsigned i = 0; i < D; i++) begin
            hit_vec[i] = valid_q[i] &
                (&(mask_mem[i] | bus.CMP_DATA_MASK | ~(data_mem[i] ^ bus.CMP_DIN)));
        end
    end

    // Stage-2 priority resolution and next-state for all registered outputs
    always_comb begin
        win_addr  = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < D; i++) begin
            if (C_MATCH_RESOLUTION == 0) begin
                if (hit1_q[i] && !win_found) begin
                    win_addr  = AW'(i);
                    win_found = 1'b1;
                end
            end else if (hit1_q[i]) begin
                win_addr = AW'(i);
            end
        end

        req1_d  = bus.CMP_REQ;
        hit1_d  = bus.CMP_REQ ? hit_vec : hit1_q;
        ack_d   = req1_q;
        match_d = req1_q ? (|hit1_q) : match_q;
        multi_d = req1_q ? (|(hit1_q & (hit1_q - HIT_ONE))) : multi_q;
        maddr_d = req1_q ? win_addr : maddr_q;

        rd_ack_d   = bus.RD_EN;
        rd_din_d   = bus.RD_EN ? data_mem[bus.RD_ADDR] : rd_din_q;
        rd_mask_d  = bus.RD_EN ? mask_mem[bus.RD_ADDR] : rd_mask_q;
        rd_valid_d = bus.RD_EN ? valid_q[bus.RD_ADDR] : rd_valid_q;

        lookup_cnt_d = lookup_cnt_q;
        hit_cnt_d    = hit_cnt_q;
        if (bus.CNT_CLR) begin
            lookup_cnt_d = '0;
            hit_cnt_d    = '0;
        end else if (ack_q) begin
            if (lookup_cnt_q != '1) lookup_cnt_d = lookup_cnt_q + CNT_ONE;
            if (match_q && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_ONE;
        end
    end

    // Valid bits, lookup pipeline, read-back and counter registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q      <= '0;
            req1_q       <= 1'b0;
            hit1_q       <= '0;
            ack_q        <= 1'b0;
            match_q      <= 1'b0;
            multi_q      <= 1'b0;
            maddr_q      <= '0;
            rd_ack_q     <= 1'b0;
            rd_din_q     <= '0;
            rd_mask_q    <= '0;
            rd_valid_q   <= 1'b0;
            lookup_cnt_q <= '0;
            hit_cnt_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            req1_q       <= req1_d;
            hit1_q       <= hit1_d;
            ack_q        <= ack_d;
            match_q      <= match_d;
            multi_q      <= multi_d;
            maddr_q      <= maddr_d;
            rd_ack_q     <= rd_ack_d;
            rd_din_q     <= rd_din_d;
            rd_mask_q    <= rd_mask_d;
            rd_valid_q   <= rd_valid_d;
            lookup_cnt_q <= lookup_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
        end
    end

    assign bus.BUSY           = busy_q;
    assign bus.CMP_ACK        = ack_q;
    assign bus.MATCH          = match_q;
    assign bus.MULTIPLE_MATCH = multi_q;
    assign bus.MATCH_ADDR     = maddr_q;
    assign bus.RD_ACK         = rd_ack_q;
    assign bus.RD_DIN_OUT     = rd_din_q;
    assign bus.RD_MASK_OUT    = rd_mask_q;
    assign bus.RD_VALID_OUT   = rd_valid_q;
    assign bus.LOOKUP_CNT     = lookup_cnt_q;
    assign bus.HIT_CNT        = hit_cnt_q;
endmodule

// File: doc/tcam_lut.md
# tcam_lut

Parametrised ternary CAM lookup table with per-entry valid bits, per-entry stored masks, and a per-lookup key mask. Lookups are pipelined, one per cycle, with configurable priority resolution. It adds a multiple-match flag, a read-back port, an automatic scrub/flush state machine and saturating lookup/hit counters. It sits in the output-port-lookup and filtering stages, serving header lookups from the datapath while the register interface programs entries.

## Interface
Parameters:
- C_TCAM_ADDR_WIDTH, 4, entry address width; depth D = 2**C_TCAM_ADDR_WIDTH.
- C_TCAM_DATA_WIDTH, 16, key and entry width W.
- C_MATCH_RESOLUTION, 0, selects which address wins on multiple hits: 0 = lowest address, 1 = highest address.
- C_CNT_WIDTH, 32, width of the statistics counters.

Ports (CLK and RESET share one clock domain):
- CLK  in  1  sole clock; all logic is rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- WE  in  1  write strobe; ignored while BUSY=1.
- WR_ADDR  in  C_TCAM_ADDR_WIDTH  entry to write.
- DIN  in  W  entry data.
- DATA_MASK  in  W  entry mask; bit=1 means don't care.
- WR_VALID  in  1  valid bit stored with the entry; 0 invalidates the entry.
- FLUSH  in  1  pulse that starts a full-table scrub; ignored while BUSY=1.
- BUSY  out  1  high while the scrub FSM is active.
- RD_EN  in  1  read-back request.
- RD_ADDR  in  C_TCAM_ADDR_WIDTH  entry to read.
- RD_DIN_OUT, RD_MASK_OUT  out  W  stored data and stored mask.
- RD_VALID_OUT  out  1  stored valid bit.
- RD_ACK  out  1  read data strobe.
- CMP_REQ  in  1  lookup request.
- CMP_DIN  in  W  lookup key.
- CMP_DATA_MASK  in  W  key mask; bit=1 means don't care.
- CMP_ACK  out  1  result strobe.
- MATCH  out  1  at least one entry hit.
- MULTIPLE_MATCH  out  1  two or more entries hit.
- MATCH_ADDR  out  C_TCAM_ADDR_WIDTH  winning entry address.
- CNT_CLR  in  1  synchronous clear of both counters.
- LOOKUP_CNT, HIT_CNT  out  C_CNT_WIDTH  saturating statistics counters.

## Operation
- **Storage.** Data and mask arrays have no reset and are RAM-inferrable. The valid vector is flops with asynchronous reset to 0.
- **Hit rule.** Entry i hits when valid[i] is set and, for every bit b, at least one of the following holds: stored_mask[b]=1, CMP_DATA_MASK[b]=1, or data[b]=CMP_DIN[b].
- **Write.** When WE=1 and BUSY=0, data, mask and valid are committed at the clock edge.
- **FSM states.** The scrub FSM has two states, IDLE and SCRUB.
  - RESET forces the FSM to SCRUB with the scrub pointer at 0.
  - In IDLE, FLUSH=1 moves the FSM to SCRUB with the pointer at 0.
  - In SCRUB, each cycle writes data=0, mask=0 and valid=0 to the entry at the pointer, then increments the pointer.
  - When the pointer reaches D-1, that entry is written and the FSM returns to IDLE on the same edge.
  - BUSY = (state == SCRUB).
- **During SCRUB.**
  - WE and FLUSH are dropped silently.
  - Lookups and reads remain legal; they see entries not yet scrubbed.
- **Match encoding.** Priority encode the hit vector per C_MATCH_RESOLUTION. MATCH_ADDR = 0 when MATCH = 0.
- **Counters.**
  - LOOKUP_CNT increments on every CMP_ACK.
  - HIT_CNT increments on every CMP_ACK with MATCH=1.
  - Both saturate at all-ones and do not wrap.
  - CNT_CLR takes priority over a same-cycle increment.

## Timing
- **Reset values.**
  - BUSY=1; it stays high for exactly D cycles after RESET deasserts.
  - CMP_ACK=0, MATCH=0, MULTIPLE_MATCH=0, MATCH_ADDR=0.
  - RD_ACK=0, RD_DIN_OUT=0, RD_MASK_OUT=0, RD_VALID_OUT=0.
  - LOOKUP_CNT=0, HIT_CNT=0.
- **Lookup pipeline.** Latency is 2 cycles with a throughput of one lookup per cycle.
  - Stage 1 registers the hit vector, computed from the table contents as they stood before the edge at which CMP_REQ is sampled.
  - Stage 2 registers CMP_ACK, MATCH, MULTIPLE_MATCH and MATCH_ADDR.
  - The result outputs hold their value while CMP_ACK=0.
- **Simultaneous events.**
  - A write or scrub step in the same cycle as CMP_REQ is not visible to that lookup; it is visible to a lookup issued on the next cycle.
- **Read-back.** Latency is 1 cycle. A read of an address being written in the same cycle returns the old contents.
- **Reset mid-operation.** RESET asserted mid-SCRUB or mid-lookup aborts everything asynchronously. In-flight lookups produce no CMP_ACK, and the scrub restarts from address 0.

## Test plan
- **Reset scrub.** Release RESET, then poll BUSY → BUSY=1 for exactly 16 cycles (defaults). A read of every address returns 0/0/0, and a lookup of key 0x0000 gives MATCH=0.
- **Exact and masked match.**
  - Write addr 3 = 0x1234 with mask 0 and addr 9 = 0x12F0 with mask 0x000F.
  - Look up 0x12F5 → CMP_ACK two cycles later with MATCH=1, MATCH_ADDR=9, MULTIPLE_MATCH=0.
  - Look up 0x1234 with CMP_DATA_MASK=0x00FF → MATCH=1, MULTIPLE_MATCH=1, MATCH_ADDR=3 (with C_MATCH_RESOLUTION=0), or 9 (with C_MATCH_RESOLUTION=1).
- **Write/lookup collision.** Write addr 5 = 0xABCD in the same cycle as a lookup of 0xABCD → MATCH=0. A back-to-back lookup issued on the next cycle → MATCH=1, MATCH_ADDR=5.
- **Invalidate and flush.**
  - Write addr 5 with WR_VALID=0 → a lookup misses.
  - Pulse FLUSH with 4 valid entries → BUSY=1 for 16 cycles, WE pulses during that window are dropped, and all lookups afterwards miss.
- **Counters.**
  - Issue 10 back-to-back lookups, 6 of them hits → LOOKUP_CNT=10, HIT_CNT=6.
  - Assert CNT_CLR coincident with a hit result → both counters read 0.
  - With C_CNT_WIDTH=4, issue 20 lookups → LOOKUP_CNT holds at 15.
